cva6_lsu_mem_responder: RTL

Memory-side responder for the CVA6 LSU model: it accepts load/store requests issued by the LSU and returns single-cycle `load_mem_resp` / `store_mem_resp` pulses after a fixed, per-type latency. Loads and stores each have an independent in-order queue. The block sits between `cva6_lsu_model`/`cva6_lsu_shim` and the bench, and replaces the hand-timed response pulses with a cycle-accurate memory.

---
 rtl/cva6_lsu_mem_pkg.sv | 17 +
 rtl/lsu_resp_queue.sv | 74 +++++++
 rtl/cva6_lsu_mem_responder.sv | 65 ++++++
 3 files changed

// File: rtl/cva6_lsu_mem_pkg.sv
// Shared types for the LSU memory responder: queue entry layout and counter width.
// Pure declarations. No logic, no latency, no backpressure.
package cva6_lsu_mem_pkg;

  localparam int TIMER_W    = 4;
  localparam int ADDR_W_MAX = 64;
  localparam int CNT_W      = 4;

  typedef logic [CNT_W-1:0] lsu_cnt_t;

  // Addresses narrower than ADDR_W_MAX are stored zero-extended.
  typedef struct packed {
    logic [ADDR_W_MAX-1:0] addr;
    logic [TIMER_W-1:0]    timer;
  } lsu_mem_entry_t;

endpackage

// File: rtl/lsu_resp_queue.sv
// In-order response queue with per-entry countdown timers; head pulses when its timer hits 0.
// Latency LAT cycles from push to pulse; no backpressure here, the caller must not push when full.
module lsu_resp_queue #(
  parameter int DEPTH  = 2,
  parameter int LAT    = 3,
  parameter int ADDR_W = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [ADDR_W-1:0]          push_addr_i,
  output logic                       resp_o,
  output logic [ADDR_W-1:0]          resp_addr_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  import cva6_lsu_mem_pkg::*;

  localparam int                 PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                 CW       = $clog2(DEPTH + 1);
  localparam logic [TIMER_W-1:0] LAT_INIT = TIMER_W'(LAT - 1);
  localparam logic [PTR_W-1:0]   LAST     = PTR_W'(DEPTH - 1);

  lsu_mem_entry_t   mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  lsu_cnt_t         count_q;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop         = vld_q[head_q] && (mem_q[head_q].timer == '0);
  assign resp_o      = pop;
  assign resp_addr_o = pop ? mem_q[head_q].addr[ADDR_W-1:0] : '0;
  assign count_o     = count_q[CW-1:0];

  // Payload storage needs no reset: vld_q gates every use of it.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (mem_q[i].timer != '0)) begin
        mem_q[i].timer <= mem_q[i].timer - TIMER_W'(1);
      end
    end
    if (push_i) begin
      mem_q[tail_q] <= '{addr: ADDR_W_MAX'(push_addr_i), timer: LAT_INIT};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= ptr_next(head_q);
      end
      if (push_i) begin
        vld_q[tail_q] <= 1'b1;
        tail_q        <= ptr_next(tail_q);
      end
      case ({push_i, pop})
        2'b10:   count_q <= count_q + lsu_cnt_t'(1);
        2'b01:   count_q <= count_q - lsu_cnt_t'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cva6_lsu_mem_responder.sv
// LSU memory responder: independent load/store queues returning one-cycle completion pulses.
// Fixed LOAD/STORE_LATENCY per type; req_ready_o drops when either queue is full (no pass-through).
module cva6_lsu_mem_responder #(
  parameter int LOAD_LATENCY  = 3,
  parameter int STORE_LATENCY = 3,
  parameter int DEPTH         = 2,
  parameter int ADDR_W        = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_valid_i,
  input  logic                       req_is_load_i,
  input  logic [ADDR_W-1:0]          req_addr_i,
  output logic                       req_ready_o,
  output logic                       load_mem_resp_o,
  output logic [ADDR_W-1:0]          load_resp_addr_o,
  output logic                       store_mem_resp_o,
  output logic [ADDR_W-1:0]          store_resp_addr_o,
  output logic [$clog2(DEPTH+1)-1:0] load_pending_o,
  output logic [$clog2(DEPTH+1)-1:0] store_pending_o
);
  import cva6_lsu_mem_pkg::*;

  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic accept;
  logic load_push;
  logic store_push;

  // Ready is a function of occupancy only, never of a same-cycle pop.
  assign req_ready_o = !rst_i && (load_pending_o < DEPTH_C) && (store_pending_o < DEPTH_C);
  assign accept      = req_valid_i && req_ready_o;
  assign load_push   = accept && req_is_load_i;
  assign store_push  = accept && !req_is_load_i;

  lsu_resp_queue #(
    .DEPTH  (DEPTH),
    .LAT    (LOAD_LATENCY),
    .ADDR_W (ADDR_W)
  ) u_load_q (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (load_push),
    .push_addr_i (req_addr_i),
    .resp_o      (load_mem_resp_o),
    .resp_addr_o (load_resp_addr_o),
    .count_o     (load_pending_o)
  );

  lsu_resp_queue #(
    .DEPTH  (DEPTH),
    .LAT    (STORE_LATENCY),
    .ADDR_W (ADDR_W)
  ) u_store_q (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (store_push),
    .push_addr_i (req_addr_i),
    .resp_o      (store_mem_resp_o),
    .resp_addr_o (store_resp_addr_o),
    .count_o     (store_pending_o)
  );

endmodule
